// File: rtl/fmadd_seq.sv
// fmadd_seq: operand FIFO and issue sequencer for a multi-cycle FMA unit.
// Holds x/y/z stable per op, captures rslt/flag, keeps sticky fflags.
module fmadd_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_z,
  output logic        fu_req,
  output logic [31:0] fu_x,
  output logic [31:0] fu_y,
  output logic [31:0] fu_z,
  input  logic [31:0] fu_rslt,
  input  logic [4:0]  fu_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rslt,
  output logic [4:0]  out_flag,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [95:0]   mem_q [FIFO_DEPTH];
  logic [95:0]   head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fu_x_q, fu_x_d;
  logic [31:0]   fu_y_q, fu_y_d;
  logic [31:0]   fu_z_q, fu_z_d;
  logic [31:0]   out_rslt_q, out_rslt_d;
  logic [4:0]    out_flag_q, out_flag_d;
  logic [4:0]    fflags_q, fflags_d;
  logic          out_valid_q, out_valid_d;
  logic          empty, full, push, pop, capture;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign push  = in_valid & ~full;
  assign head  = mem_q[rd_ptr_q];

  // Sequencer: pop into unit, pulse req, count latency, hold result
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, operand latches, result capture and sticky flags
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    fill_d     = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    fu_x_d     = pop ? head[95:64] : fu_x_q;
    fu_y_d     = pop ? head[63:32] : fu_y_q;
    fu_z_d     = pop ? head[31:0]  : fu_z_q;
    out_rslt_d = capture ? fu_rslt : out_rslt_q;
    out_flag_d = capture ? fu_flag : out_flag_q;
    fflags_d   = fflags_clr ? 5'd0 : fflags_q;
    if (capture) fflags_d = fflags_d | fu_flag;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fu_x_q      <= '0;
      fu_y_q      <= '0;
      fu_z_q      <= '0;
      out_rslt_q  <= '0;
      out_flag_q  <= '0;
      fflags_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fu_x_q      <= fu_x_d;
      fu_y_q      <= fu_y_d;
      fu_z_q      <= fu_z_d;
      out_rslt_q  <= out_rslt_d;
      out_flag_q  <= out_flag_d;
      fflags_q    <= fflags_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y, in_z};
  end

  assign in_ready  = ~full;
  assign fu_req    = (state_q == S_ISSUE);
  assign fu_x      = fu_x_q;
  assign fu_y      = fu_y_q;
  assign fu_z      = fu_z_q;
  assign out_valid = out_valid_q;
  assign out_rslt  = out_rslt_q;
  assign out_flag  = out_flag_q;
  assign fflags    = fflags_q;
  assign busy      = ~empty | (state_q != S_IDLE);

endmodule

// File: tb/tb_fmadd_seq.sv
// tb_fmadd_seq: directed + random checks of fmadd_seq against a
// behavioural FMA unit and result scoreboard.
module tb_fmadd_seq;

  localparam int LATENCY = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y, in_z;
  logic        fu_req;
  logic [31:0] fu_x, fu_y, fu_z;
  logic [31:0] fu_rslt;
  logic [4:0]  fu_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rslt;
  logic [4:0]  out_flag;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int consec = 0;
  logic req_prev = 1'b0;
  logic [4:0] exp_ff;
  logic [36:0] q[$];

  fmadd_seq #(.FIFO_DEPTH(4), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .fu_req(fu_req), .fu_x(fu_x), .fu_y(fu_y), .fu_z(fu_z),
    .fu_rslt(fu_rslt), .fu_flag(fu_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rslt(out_rslt), .out_flag(out_flag),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference FMA: real results for the directed triples, a hash otherwise
  function automatic logic [36:0] fma_ref(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] z);
    if (x == 32'h3F800000 && y == 32'h40000000 && z == 32'h3F000000)
      return {32'h40200000, 5'b00000};
    if (x == 32'h7F800000 && y == 32'h00000000 && z == 32'h3F800000)
      return {32'hFFC00000, 5'b10000};
    if (x == 32'h3F800000 && y == 32'h3F800000 && z == 32'h33800000)
      return {32'h3F800000, 5'b00001};
    return {x ^ {y[24:0], y[31:25]} ^ (z + 32'h9E3779B9),
            x[4:0] ^ y[9:5] ^ z[14:10]};
  endfunction

  // Behavioural unit: garbage until LATENCY cycles after req, then the
  // result of whatever operands it currently sees
  int ucnt = 0;
  logic uvalid = 1'b0;
  logic [36:0] garb = '0;
  logic [36:0] unit_val;
  assign unit_val = fma_ref(fu_x, fu_y, fu_z);
  assign fu_rslt = uvalid ? unit_val[36:5] : garb[36:5];
  assign fu_flag = uvalid ? unit_val[4:0] : garb[4:0];

  always @(posedge clk) begin
    garb <= {$urandom, 5'($urandom)};
    if (reset) begin
      ucnt <= 0;
      uvalid <= 1'b0;
    end else if (fu_req) begin
      ucnt <= LATENCY;
      uvalid <= 1'b0;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else if (ucnt == 1) begin
      ucnt <= 0;
      uvalid <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (fu_req && req_prev) consec++;
    if (fu_req) req_cnt++;
    req_prev <= fu_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input int hold);
    logic [36:0] e;
    int n;
    e = fma_ref(x, y, z);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_z = z;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("op_valid", out_valid, 1);
    repeat (hold) tick();
    chk("op_rslt", out_rslt, e[36:5]);
    chk("op_flag", out_flag, e[4:0]);
    exp_ff = exp_ff | e[4:0];
    chk("op_fflags", fflags, exp_ff);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("op_released", out_valid, 0);
  endtask

  initial begin
    int n, r0, last, bad;
    logic [31:0] x0, fx, fy, fz;
    logic [36:0] e;

    reset = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_z = '0;
    out_ready = 1'b0;
    fflags_clr = 1'b0;
    exp_ff = '0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fu_req", fu_req, 0);
    chk("rst_fu_x", fu_x, 0);
    chk("rst_out_rslt", out_rslt, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // single op, latency and req pulse
    in_valid = 1'b1;
    in_x = 32'h3F800000;
    in_y = 32'h40000000;
    in_z = 32'h3F000000;
    r0 = req_cnt;
    tick();
    in_valid = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_req_pre", fu_req, 0);
    tick();
    chk("t1_req", fu_req, 1);
    chk("t1_fu_x", fu_x, 32'h3F800000);
    tick();
    chk("t1_req_drop", fu_req, 0);
    n = 2;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk("t1_latency", n, LATENCY + 3);
    chk("t1_rslt", out_rslt, 32'h40200000);
    chk("t1_flag", out_flag, 5'b00000);
    chk("t1_fflags", fflags, 5'b00000);
    chk("t1_req_count", req_cnt - r0, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_valid_clr", out_valid, 0);
    chk("t1_idle", busy, 0);

    // invalid op then clean op, sticky flags, clear
    do_op(32'h7F800000, 32'h00000000, 32'h3F800000, 2);
    chk("t2_nv_rslt", out_rslt, 32'hFFC00000);
    chk("t2_nv_ff", fflags, 5'b10000);
    do_op(32'h3F800000, 32'h40000000, 32'h3F000000, 0);
    chk("t2_sticky", fflags, 5'b10000);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    exp_ff = '0;
    chk("t2_cleared", fflags, 5'b00000);

    // backpressure, FIFO fill, operand stability, ordered drain
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_x = $urandom;
      in_y = $urandom;
      in_z = $urandom;
      if (i == 0) x0 = in_x;
      chk(i == 5 ? "t3_full" : "t3_ready", in_ready, (i < 5) ? 1 : 0);
      if (in_ready) q.push_back(fma_ref(in_x, in_y, in_z));
      tick();
    end
    fx = fu_x;
    fy = fu_y;
    fz = fu_z;
    chk("t3_fu_x_op0", fu_x, x0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      in_x = $urandom;
      in_y = $urandom;
      in_z = $urandom;
      tick();
      if (fu_x !== fx || fu_y !== fy || fu_z !== fz || in_ready) bad++;
    end
    in_valid = 1'b0;
    chk("t3_stable", bad, 0);
    chk("t3_done_wait", out_valid, 1);
    out_ready = 1'b1;
    last = -1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      if (out_valid) begin
        e = q.pop_front();
        chk("t3_rslt", out_rslt, e[36:5]);
        chk("t3_flag", out_flag, e[4:0]);
        exp_ff = exp_ff | e[4:0];
        if (last >= 0) chk("t3_interval", n - last, LATENCY + 3);
        last = n;
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("t3_drained", q.size(), 0);
    chk("t3_fflags", fflags, exp_ff);
    chk("t3_idle", busy, 0);

    // clear coinciding with capture of an NX op
    do_op(32'h7F800000, 32'h00000000, 32'h3F800000, 0);
    in_valid = 1'b1;
    in_x = 32'h3F800000;
    in_y = 32'h3F800000;
    in_z = 32'h33800000;
    tick();
    in_valid = 1'b0;
    repeat (LATENCY + 2) tick();
    chk("t5_pre_capture", out_valid, 0);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    chk("t5_captured", out_valid, 1);
    chk("t5_flag", out_flag, 5'b00001);
    chk("t5_fflags", fflags, 5'b00001);
    exp_ff = 5'b00001;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset during WAIT with two ops queued
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_x = $urandom;
      in_y = $urandom;
      in_z = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t6_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_fu_req", fu_req, 0);
    chk("t6_fflags", fflags, 0);
    reset = 1'b0;
    exp_ff = '0;
    out_ready = 1'b1;
    bad = 0;
    repeat (30) begin
      tick();
      if (out_valid || fu_req) bad++;
    end
    out_ready = 1'b0;
    chk("t6_no_stale", bad, 0);

    // random ops with random consumer delay
    for (int k = 0; k < 10; k++)
      do_op($urandom, $urandom, $urandom, int'($urandom_range(0, 3)));

    chk("req_never_consec", consec, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fmadd_seq.md
Name: fmadd_seq

Overview:
- Issue sequencer directly upstream of the multi-cycle single-precision fused multiply-add unit.
- Buffers FMA operand triples in a small FIFO and drives the unit's req/x/y/z inputs, holding x/y/z stable for the whole operation.
- Captures rslt/flag after the unit's fixed latency and presents them on a valid/ready result port.
- Keeps a sticky accumulated exception-flag register.

Parameters:
FIFO_DEPTH, 4, operand FIFO entries; power of two, >=2
LATENCY, 6, unit cycles after the req cycle until rslt/flag are valid

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  operand triple offered
in_ready  out  1  FIFO can accept; equals !full
in_x  in  32  multiplicand (IEEE single)
in_y  in  32  multiplier
in_z  in  32  addend
fu_req  out  1  start pulse to FMA unit
fu_x  out  32  operand x to unit, registered
fu_y  out  32  operand y to unit, registered
fu_z  out  32  operand z to unit, registered
fu_rslt  in  32  unit result
fu_flag  in  5  unit flags {NV,DZ,OF,UF,NX}
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_rslt  out  32  captured result
out_flag  out  5  captured flags
fflags  out  5  sticky OR of all captured flags
fflags_clr  in  1  clear fflags
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: every output 0; FIFO empty; state IDLE; cnt 0. in_ready reads 1 the cycle after reset.
- FIFO:
  - Push when in_valid & in_ready. Pop only on the FSM transitions below.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - When full, in_ready=0: no push, no bypass. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if FIFO non-empty, pop head into fu_x/fu_y/fu_z and go to ISSUE; else stay.
  - ISSUE: fu_req=1 for exactly this cycle. Load cnt=LATENCY and go to WAIT.
  - WAIT: if cnt!=0, decrement. If cnt==0, capture fu_rslt->out_rslt and fu_flag->out_flag, set out_valid=1, fflags <= fflags|fu_flag, go to DONE.
  - DONE: hold out_* stable while out_ready=0. On out_ready=1, clear out_valid; if FIFO non-empty, pop into fu_x/y/z and go to ISSUE (back-to-back); else go to IDLE.
- fu_x/y/z change only on a pop edge. They are held from pop through DONE, as the unit reads them until its final cycle.
- fu_req is asserted only in ISSUE and is never asserted for two consecutive cycles.
- Latency: with IDLE and an empty FIFO, an accept at edge T gives fu_req high in cycle T+1..T+2 and out_valid rising at edge T+LATENCY+3.
- Steady-state issue interval is LATENCY+3 cycles with out_ready held high.
- fflags_clr: clears fflags at the edge. If it coincides with a capture, fflags <= fu_flag (clear, then OR).
- Reset mid-operation (any state) drops the in-flight op and all FIFO contents, deasserts out_valid and fu_req, and returns to IDLE. A subsequent req fully re-initialises the unit.
- The sequencer does no arithmetic on operands or results; values pass through bit-exact.

Test Plan:
- Single op x=3F800000, y=40000000, z=3F000000 against the real FMA unit -> out_rslt=40200000, out_flag=00000, out_valid rises at T+9, fu_req is a single-cycle pulse.
- Invalid op x=7F800000, y=00000000, z=3F800000 -> out_rslt=FFC00000, out_flag=10000, fflags=10000. A later clean op leaves fflags=10000. fflags_clr pulse -> 00000.
- Backpressure: push 6 ops with out_ready=0 -> one op in DONE, 4 in FIFO, in_ready=0 on the 6th offer. Releasing out_ready drains all results in order with intervals of 9 cycles.
- Operand stability: change in_x/y/z every cycle during WAIT -> fu_x/y/z stay constant until the DONE->ISSUE pop.
- fflags_clr asserted on the capture edge of an op with flag=00001 -> fflags=00001.
- Reset asserted in WAIT with 2 ops queued -> next cycle out_valid=0, busy=0, in_ready=1. No stale result appears afterwards.
